hazard_control_unit: RTL and testbench

- Generates the pipeline control signals consumed by the pipeline register block: `stall` (ID/EX bubble, front end held) and `takebranch` (IF/ID and ID/EX flush).
- Also produces `freeze` for whole-pipeline holds during memory waits, plus PC control and performance counters.
- Sits beside the pipeline registers and the PC logic. It takes decode-stage register operands, execute-stage load/branch status, and the data-memory handshake.

---
 rtl/hazard_control_unit_pkg.sv | 37 +++
 rtl/hazard_control_unit_load_use_detector.sv | 35 +++
 rtl/hazard_control_unit.sv | 170 +++++++++++++++++
 tb/tb_hazard_control_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_pkg
//
// Shared types for the hazard control unit and the pipeline register block
// that consumes its control bundle.
//   hz_state_t    : controller mode (normal run, waiting on data memory,
//                   permanently frozen after a memory timeout)
//   hazard_ctrl_t : control bundle wired to the pipeline registers / PC
//   hz_ctrl_idle  : all-zero control bundle, used as the default value
// ---------------------------------------------------------------------------
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_MEM_WAIT,
        HZ_TIMEOUT
    } hz_state_t;

    typedef struct packed {
        logic stall;
        logic takebranch;
        logic freeze;
        logic pc_write_en;
        logic pc_redirect;
    } hazard_ctrl_t;

    function automatic hazard_ctrl_t hz_ctrl_idle();
        hazard_ctrl_t c;
        c.stall       = 1'b0;
        c.takebranch  = 1'b0;
        c.freeze      = 1'b0;
        c.pc_write_en = 1'b0;
        c.pc_redirect = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/hazard_control_unit_load_use_detector.sv
// ---------------------------------------------------------------------------
// load_use_detector
//
// Purely combinational detection of a load-use hazard: the instruction in EX
// is a load whose destination register is read by the instruction in ID.
// Register 0 is hard-wired to zero, so a load targeting it never creates a
// dependency.
//
// Ports:
//   id_rs1, id_rs2           : source registers of the ID instruction
//   id_uses_rs1, id_uses_rs2 : ID instruction actually reads that source
//   ex_rd                    : destination register of the EX instruction
//   ex_mem_read              : EX instruction is a load
//   load_use                 : hazard present this cycle
// ---------------------------------------------------------------------------
module load_use_detector #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use  = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Produces the pipeline control signals (stall, takebranch, freeze), PC
// control, a sticky memory-timeout error and two performance counters.
// All control outputs are Mealy: they combine the registered mode with the
// current inputs so the pipeline registers act on them at the same edge.
//
// Ports:
//   clock, reset                  : rising-edge clock, async active-low reset
//   id_rs1/id_rs2/id_uses_rs*     : ID-stage source operands
//   ex_rd/ex_mem_read             : EX-stage load destination
//   ex_branch_taken/_target       : EX-stage branch resolution
//   mem_req_valid/mem_ready       : data-memory handshake
//   stall/takebranch/freeze       : pipeline register control
//   pc_write_en/pc_redirect/pc_target : PC control
//   mem_timeout                   : memory never answered; held until reset
//   stall_count/flush_count       : wrapping performance counters
// ---------------------------------------------------------------------------
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int XLEN         = 32,
    parameter int CNT_W        = 32,
    parameter int MAX_MEM_WAIT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic [XLEN-1:0]       ex_branch_target,
    input  logic                  mem_req_valid,
    input  logic                  mem_ready,
    output logic                  stall,
    output logic                  takebranch,
    output logic                  freeze,
    output logic                  pc_write_en,
    output logic                  pc_redirect,
    output logic [XLEN-1:0]       pc_target,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    hazard_ctrl_t      ctrl;
    logic [XLEN-1:0]   target;
    logic              timeout;
    logic              load_use;
    logic              mem_block;

    load_use_detector #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detector (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign mem_block = mem_req_valid && !mem_ready;

    // Next-state and control outputs. A memory block outranks a branch,
    // which outranks a load-use stall (the ID instruction is wrong-path when
    // a branch is taken). While waiting on memory, branch and load-use logic
    // is ignored: EX holds its instruction, so the branch is seen again on
    // the first RUN cycle. Outputs are forced low while reset is asserted.
    always_comb begin
        ctrl       = hz_ctrl_idle();
        target     = '0;
        timeout    = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            HZ_RUN: begin
                if (mem_block) begin
                    ctrl.freeze = 1'b1;
                    state_d     = HZ_MEM_WAIT;
                    wait_cnt_d  = WAIT_W'(1);
                end else if (ex_branch_taken) begin
                    ctrl.takebranch  = 1'b1;
                    ctrl.pc_redirect = 1'b1;
                    target           = ex_branch_target;
                end else if (load_use) begin
                    ctrl.stall = 1'b1;
                end
            end
            HZ_MEM_WAIT: begin
                ctrl.freeze = !mem_ready;
                if (mem_ready) begin
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MAX_MEM_WAIT)) begin
                    state_d = HZ_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            HZ_TIMEOUT: begin
                ctrl.freeze = 1'b1;
                timeout     = 1'b1;
            end
            default: begin
                state_d    = HZ_RUN;
                wait_cnt_d = '0;
            end
        endcase

        ctrl.pc_write_en = !ctrl.stall && !ctrl.freeze;

        if (!reset) begin
            ctrl    = hz_ctrl_idle();
            target  = '0;
            timeout = 1'b0;
        end
    end

    // Performance counters wrap naturally at 2^CNT_W.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (ctrl.stall || ctrl.freeze) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (ctrl.takebranch) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= HZ_RUN;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall       = ctrl.stall;
    assign takebranch  = ctrl.takebranch;
    assign freeze      = ctrl.freeze;
    assign pc_write_en = ctrl.pc_write_en;
    assign pc_redirect = ctrl.pc_redirect;
    assign pc_target   = target;
    assign mem_timeout = timeout;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Drives directed scenarios followed by random traffic. For every cycle the
// stimulus process computes the expected outputs from a behavioural model and
// queues them; a separate monitor samples the DUT on the falling edge and
// compares against the queue head.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam int REG_ADDR_W   = 5;
    localparam int XLEN         = 32;
    localparam int CNT_W        = 8;
    localparam int MAX_MEM_WAIT = 4;
    localparam int CNT_MOD      = 1 << CNT_W;

    logic                  clock;
    logic                  reset;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic                  id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic                  ex_branch_taken;
    logic [XLEN-1:0]       ex_branch_target;
    logic                  mem_req_valid, mem_ready;
    logic                  stall, takebranch, freeze, pc_write_en, pc_redirect;
    logic [XLEN-1:0]       pc_target;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_count, flush_count;

    typedef struct {
        bit              rst_n;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        bit              u1;
        bit              u2;
        logic [4:0]      rd;
        bit              mr;
        bit              bt;
        logic [31:0]     tgt;
        bit              mv;
        bit              rdy;
    } stim_t;

    typedef struct {
        bit          stall;
        bit          tb;
        bit          frz;
        bit          pcw;
        bit          pcr;
        logic [31:0] tgt;
        bit          to;
        int          sc;
        int          fc;
        int          cyc;
    } exp_t;

    exp_t expq[$];

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;

    // Reference model state: whether we are waiting on memory, how many
    // consecutive unanswered memory cycles so far, whether the memory was
    // declared dead, and the running counter values.
    bit m_waiting   = 0;
    int m_unanswered = 0;
    bit m_dead      = 0;
    int m_sc        = 0;
    int m_fc        = 0;

    hazard_control_unit #(
        .REG_ADDR_W   (REG_ADDR_W),
        .XLEN         (XLEN),
        .CNT_W        (CNT_W),
        .MAX_MEM_WAIT (MAX_MEM_WAIT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs1      (id_uses_rs1),
        .id_uses_rs2      (id_uses_rs2),
        .ex_rd            (ex_rd),
        .ex_mem_read      (ex_mem_read),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .mem_req_valid    (mem_req_valid),
        .mem_ready        (mem_ready),
        .stall            (stall),
        .takebranch       (takebranch),
        .freeze           (freeze),
        .pc_write_en      (pc_write_en),
        .pc_redirect      (pc_redirect),
        .pc_target        (pc_target),
        .mem_timeout      (mem_timeout),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1;
        s.rs1   = '0;
        s.rs2   = '0;
        s.u1    = 1'b0;
        s.u2    = 1'b0;
        s.rd    = '0;
        s.mr    = 1'b0;
        s.bt    = 1'b0;
        s.tgt   = '0;
        s.mv    = 1'b0;
        s.rdy   = 1'b0;
        return s;
    endfunction

    // Drive one cycle of inputs, derive the expected response and wait for
    // the clock edge that consumes them.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   lu;
        bit   blocked;

        reset            = s.rst_n;
        id_rs1           = s.rs1;
        id_rs2           = s.rs2;
        id_uses_rs1      = s.u1;
        id_uses_rs2      = s.u2;
        ex_rd            = s.rd;
        ex_mem_read      = s.mr;
        ex_branch_taken  = s.bt;
        ex_branch_target = s.tgt;
        mem_req_valid    = s.mv;
        mem_ready        = s.rdy;

        e.stall = 0; e.tb = 0; e.frz = 0; e.pcw = 0; e.pcr = 0;
        e.tgt = '0; e.to = 0; e.sc = 0; e.fc = 0; e.cyc = cyc;

        if (!s.rst_n) begin
            m_waiting    = 0;
            m_unanswered = 0;
            m_dead       = 0;
            m_sc         = 0;
            m_fc         = 0;
        end else begin
            lu = s.mr && (s.rd != 0) &&
                 ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
            blocked = s.mv && !s.rdy;
            e.sc = m_sc;
            e.fc = m_fc;
            if (m_dead) begin
                e.frz = 1;
                e.to  = 1;
            end else if (m_waiting) begin
                e.frz = !s.rdy;
                if (s.rdy) begin
                    m_waiting = 0;
                end else begin
                    m_unanswered++;
                    if (m_unanswered > MAX_MEM_WAIT) m_dead = 1;
                end
            end else if (blocked) begin
                e.frz        = 1;
                m_waiting    = 1;
                m_unanswered = 1;
            end else if (s.bt) begin
                e.tb  = 1;
                e.pcr = 1;
                e.tgt = s.tgt;
            end else if (lu) begin
                e.stall = 1;
            end
            e.pcw = !e.stall && !e.frz;
            if (e.stall || e.frz) m_sc = (m_sc + 1) % CNT_MOD;
            if (e.tb) m_fc = (m_fc + 1) % CNT_MOD;
        end

        expq.push_back(e);
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act,
                              input logic [31:0] exp, input int c);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                     name, c, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("stall",       {31'b0, stall},       {31'b0, e.stall}, e.cyc);
        checkField("takebranch",  {31'b0, takebranch},  {31'b0, e.tb},    e.cyc);
        checkField("freeze",      {31'b0, freeze},      {31'b0, e.frz},   e.cyc);
        checkField("pc_write_en", {31'b0, pc_write_en}, {31'b0, e.pcw},   e.cyc);
        checkField("pc_redirect", {31'b0, pc_redirect}, {31'b0, e.pcr},   e.cyc);
        checkField("pc_target",   pc_target,            e.tgt,            e.cyc);
        checkField("mem_timeout", {31'b0, mem_timeout}, {31'b0, e.to},    e.cyc);
        checkField("stall_count", {24'b0, stall_count}, e.sc,             e.cyc);
        checkField("flush_count", {24'b0, flush_count}, e.fc,             e.cyc);
    endtask

    // Monitor: every cycle's outputs are valid; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        stim_t s;

        reset = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = '0; ex_mem_read = 0; ex_branch_taken = 0;
        ex_branch_target = '0; mem_req_valid = 0; mem_ready = 0;
        @(posedge clock);
        #1;

        // Reset held, then released.
        s = idle(); s.rst_n = 0;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idle());

        // Load-use on rs1, then the bubble cycle.
        s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
        applyStimulus(s);
        applyStimulus(idle());

        // Same with rd = 0: no hazard.
        s.rd = 0; s.rs1 = 0;
        applyStimulus(s);

        // Load-use on rs2 only.
        s = idle(); s.mr = 1; s.rd = 9; s.rs2 = 9; s.u2 = 1; s.rs1 = 9;
        applyStimulus(s);

        // Branch together with load-use: branch wins.
        s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
        s.bt = 1; s.tgt = 32'h0000_0100;
        applyStimulus(s);
        applyStimulus(idle());

        // Three blocked memory cycles, then ready.
        s = idle(); s.mv = 1; s.rdy = 0;
        repeat (3) applyStimulus(s);
        s.rdy = 1;
        applyStimulus(s);
        applyStimulus(idle());

        // Branch pending during a memory wait, taken on the first RUN cycle.
        s = idle(); s.mv = 1; s.rdy = 0; s.bt = 1; s.tgt = 32'hDEAD_BEE0;
        repeat (2) applyStimulus(s);
        s.rdy = 1;
        applyStimulus(s);
        s.mv = 0; s.rdy = 0;
        applyStimulus(s);
        applyStimulus(idle());

        // Asynchronous reset in the middle of a memory wait.
        s = idle(); s.mv = 1; s.rdy = 0;
        repeat (3) applyStimulus(s);
        s.rst_n = 0;
        applyStimulus(s);
        applyStimulus(idle());

        // Timeout: memory never answers; a late ready pulse is ignored and
        // the permanent freeze wraps the stall counter.
        s = idle(); s.mv = 1; s.rdy = 0;
        for (int i = 0; i < 10; i++) begin
            s.rdy = (i == 7);
            applyStimulus(s);
        end
        s = idle(); s.bt = 1; s.tgt = 32'h40;
        repeat (270) applyStimulus(s);
        s = idle(); s.rst_n = 0;
        applyStimulus(s);
        applyStimulus(idle());

        // Timeout boundary: answered exactly on the last allowed cycle.
        s = idle(); s.mv = 1; s.rdy = 0;
        repeat (MAX_MEM_WAIT) applyStimulus(s);
        s.rdy = 1;
        applyStimulus(s);
        applyStimulus(idle());

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(0, 99) >= 2);
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.u1    = 1'($urandom_range(0, 1));
            s.u2    = 1'($urandom_range(0, 1));
            s.rd    = 5'($urandom_range(0, 3));
            s.mr    = 1'($urandom_range(0, 1));
            s.bt    = ($urandom_range(0, 3) == 0);
            s.tgt   = $urandom;
            s.mv    = ($urandom_range(0, 9) < 3);
            s.rdy   = 1'($urandom_range(0, 1));
            applyStimulus(s);
        end
        applyStimulus(idle());

        @(negedge clock);
        #1;
        checkField("queue_drained", expq.size(), 32'd0, cyc);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
